// File: rtl/io_cfg_pkg.sv
// Shared constants and types for the serial I/O-bank configuration loader.
package io_cfg_pkg;

  localparam logic [7:0]  SYNC_WORD = 8'hA5;
  localparam int unsigned REC_W     = 3;

  typedef enum logic [1:0] {
    HUNT,
    LOAD,
    COMMIT
  } state_t;

  localparam logic [1:0] TSM_HIZ   = 2'b00;
  localparam logic [1:0] TSM_TSCTL = 2'b01;
  localparam logic [1:0] TSM_DRIVE = 2'b10;

  // Pin-driver enable implied by a tristate-mux select; 2'b11 also drives.
  function automatic logic tsm_drives(input logic [1:0] tsm, input logic ts);
    if ((tsm & TSM_DRIVE) != '0) return 1'b1;
    else if (tsm == TSM_TSCTL)   return ts;
    else                         return 1'b0;
  endfunction

endpackage

// File: rtl/io_cfg_sync_det.sv
// 8-bit sliding-window sync-word matcher; match reflects the post-shift window.
module io_cfg_sync_det
  import io_cfg_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic din,
  output logic match
);

  logic [7:0] win;
  logic [7:0] win_next;

  assign win_next = {win[6:0], din};
  assign match    = en && (win_next == SYNC_WORD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      win <= '0;
    else if (clr) win <= '0;
    else if (en)  win <= win_next;
  end

endmodule

// File: rtl/io_cfg_loader.sv
// Serial configuration loader: hunts for the sync word, shifts in per-IOB records,
// checks even parity and commits the whole bank in one cycle.
module io_cfg_loader
  import io_cfg_pkg::*;
#(
  parameter int unsigned NUM_IOB = 8,
  parameter int unsigned CNT_W   = $clog2(3 * NUM_IOB + 1)
) (
  input  logic                   CFGCLK,
  input  logic                   RST,
  input  logic                   CFG_DIN,
  input  logic                   CFG_EN,
  output logic [2*NUM_IOB-1:0]   TSMUX,
  output logic [NUM_IOB-1:0]     DORREG,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   ERR
);

  localparam int unsigned       PAY_W    = REC_W * NUM_IOB;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(PAY_W);

  state_t              state;
  logic [PAY_W-1:0]    shadow;
  logic [CNT_W-1:0]    cnt;
  logic                par;
  logic                par_ok;
  logic                sync_hit;
  logic [2*NUM_IOB-1:0] ts_next;
  logic [NUM_IOB-1:0]  dr_next;

  io_cfg_sync_det u_sync (
    .clk   (CFGCLK),
    .rst   (RST),
    .en    (CFG_EN && (state == HUNT)),
    .clr   (sync_hit),
    .din   (CFG_DIN),
    .match (sync_hit)
  );

  // Record i occupies shadow[3i+2:3i] as {tsmux[1], tsmux[0], dorreg}.
  always_comb begin
    ts_next = '0;
    dr_next = '0;
    for (int unsigned i = 0; i < NUM_IOB; i++) begin
      ts_next[2*i+1] = shadow[REC_W*i+2];
      ts_next[2*i]   = shadow[REC_W*i+1];
      dr_next[i]     = shadow[REC_W*i];
    end
  end

  always_ff @(posedge CFGCLK or posedge RST) begin
    if (RST) begin
      state  <= HUNT;
      shadow <= '0;
      cnt    <= '0;
      par    <= 1'b0;
      par_ok <= 1'b0;
      TSMUX  <= {NUM_IOB{TSM_HIZ}};
      DORREG <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      unique case (state)
        HUNT: begin
          if (sync_hit) begin
            state <= LOAD;
            BUSY  <= 1'b1;
            DONE  <= 1'b0;
            ERR   <= 1'b0;
            cnt   <= '0;
            par   <= 1'b0;
          end
        end
        LOAD: begin
          if (CFG_EN) begin
            if (cnt == LAST_CNT) begin
              state  <= COMMIT;
              par_ok <= ~(par ^ CFG_DIN);
            end else begin
              shadow <= {shadow[PAY_W-2:0], CFG_DIN};
              par    <= par ^ CFG_DIN;
              cnt    <= cnt + CNT_W'(1);
            end
          end
        end
        COMMIT: begin
          state <= HUNT;
          BUSY  <= 1'b0;
          if (par_ok) begin
            TSMUX  <= ts_next;
            DORREG <= dr_next;
            DONE   <= 1'b1;
          end else begin
            ERR <= 1'b1;
          end
        end
        default: begin
          state <= HUNT;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule
